regfile_sb: RTL and testbench

Parametrised register file for the decode stage with registered read ports, same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a self-clearing initialisation sequence after reset. It sits between the instruction decoder, which supplies read addresses and issues destination registers, and writeback, which supplies write data. It is the next-generation replacement for the fixed 2-read/1-write, 32x32 register file.

---
 rtl/regfile_sb_if.sv | 36 +++
 rtl/regfile_sb.sv | 123 ++++++++++++
 tb/tb_regfile_sb.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Decoder/writeback-facing bus of the decode-stage register file.
// Latency: n/a (signal bundle only).
// Backpressure: none on the bus; hazards are reported through rd_busy, and ready gates use after reset.
//
// Signals:
//   rd_addr  : NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  : NUM_RD packed registered read data, packed like rd_addr
//   rd_busy  : per-port registered scoreboard bit
//   wr_en/wr_addr/wr_data : writeback strobe, address and data
//   iss_en/iss_addr       : issue strobe and destination register
//   ready    : high once the post-reset clear sequence has finished
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) ();
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, ready
    );
endinterface

// File: rtl/regfile_sb.sv
// Decode-stage register file with write-first bypass, busy scoreboard and self-clearing init.
// Latency: 1 cycle from rd_addr to rd_data/rd_busy; init takes 2**ADDR_W cycles after reset.
// Backpressure: none; writes/issues are accepted every RUN cycle and ignored while ready is low.
//
// Ports:
//   clk   : single clock, everything updates on posedge
//   rst_n : synchronous active-low reset, restarts the clear sequence
//   bus   : regfile_sb_if slave modport (read ports, writeback, issue, ready)
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    busy, busy_nxt;
    logic                wr_eff, iss_eff;
    logic [ADDR_W-1:0]   rd_addr_a [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_nxt;
    logic [NUM_RD-1:0]   rd_busy_q, rd_busy_nxt;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_addr
        assign rd_addr_a[g] = bus.rd_addr[g*ADDR_W +: ADDR_W];
    end

    // Register 0 is hard-wired when ZERO_REG is set, so its writes and issues
    // are dropped here and never reach the array, scoreboard or bypass.
    assign wr_eff  = (state == RUN) && bus.wr_en
                     && !(ZERO_REG && (bus.wr_addr == '0));
    assign iss_eff = (state == RUN) && bus.iss_en
                     && !(ZERO_REG && (bus.iss_addr == '0));

    // Next-state logic: INIT walks the clear counter across every address.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            INIT: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (&clr_cnt) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Scoreboard update: write clears first, issue sets after, so an issue and
    // write to the same register in one cycle leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_eff) begin
            busy_nxt[bus.wr_addr] = 1'b0;
        end
        if (iss_eff) begin
            busy_nxt[bus.iss_addr] = 1'b1;
        end
    end

    // Read path: same-cycle writeback data wins over the array contents, and
    // the busy bit reported is the one after this cycle's write and issue.
    always_comb begin
        rd_data_nxt = '0;
        rd_busy_nxt = '0;
        if (state == RUN) begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (!(ZERO_REG && (rd_addr_a[i] == '0))) begin
                    rd_data_nxt[i*DATA_W +: DATA_W] =
                        (wr_eff && (bus.wr_addr == rd_addr_a[i])) ? bus.wr_data
                                                                  : regs[rd_addr_a[i]];
                    rd_busy_nxt[i] = busy_nxt[rd_addr_a[i]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            clr_cnt   <= '0;
            busy      <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            busy      <= busy_nxt;
            rd_data_q <= rd_data_nxt;
            rd_busy_q <= rd_busy_nxt;
        end
    end

    // Array storage has no reset of its own; the INIT walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                regs[clr_cnt] <= '0;
            end else if (wr_eff) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_busy = rd_busy_q;
    assign bus.ready   = (state == RUN);

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    regfile_sb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents, busy set, and the
    // number of clear cycles still owed after reset.
    logic [DATA_W-1:0] m_regs [DEPTH];
    logic [DEPTH-1:0]  m_busy;
    int                m_left;
    logic              m_ready;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return bus.rd_addr[i*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input int i);
        return bus.rd_data[i*DATA_W +: DATA_W];
    endfunction

    // Advance one clock, predicting outputs from the inputs currently driven,
    // then compare every output 1ns after the edge.
    task automatic tick(input string tag);
        logic [DATA_W-1:0] exp_d [NUM_RD];
        logic              exp_b [NUM_RD];
        for (int i = 0; i < NUM_RD; i++) begin
            exp_d[i] = '0;
            exp_b[i] = 1'b0;
        end
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) m_regs[r] = '0;
            m_busy  = '0;
            m_left  = DEPTH;
            m_ready = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (addr_of(i) == 0)
                    exp_d[i] = '0;
                else if (bus.wr_en && bus.wr_addr == addr_of(i))
                    exp_d[i] = bus.wr_data;
                else
                    exp_d[i] = m_regs[addr_of(i)];
            end
            if (bus.wr_en && bus.wr_addr != 0) begin
                m_regs[bus.wr_addr] = bus.wr_data;
                m_busy[bus.wr_addr] = 1'b0;
            end
            if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
            for (int i = 0; i < NUM_RD; i++) exp_b[i] = m_busy[addr_of(i)];
        end
        @(posedge clk);
        #1;
        chk({tag, ".ready"}, {31'b0, bus.ready}, {31'b0, m_ready});
        for (int i = 0; i < NUM_RD; i++) begin
            chk($sformatf("%s.data%0d", tag, i), data_of(i), exp_d[i]);
            chk($sformatf("%s.busy%0d", tag, i), {31'b0, bus.rd_busy[i]}, {31'b0, exp_b[i]});
        end
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    // Run the clear sequence out and return how many cycles ready stayed low.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.ready && n < 100) begin
            tick(tag);
            n++;
        end
        chk({tag, ".len"}, DATA_W'(n), DATA_W'(DEPTH));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_left   = DEPTH;
        m_ready  = 1'b0;
        m_busy   = '0;
        rst_n    = 1'b0;
        idle();
        set_rd(0, 0);

        // Reset held 3 cycles, with writes/issues asserted to show they are ignored.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h1111_2222;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
        for (int k = 0; k < 3; k++) tick("reset");
        rst_n = 1'b1;
        wait_ready("init");
        idle();

        // Every register reads zero and not busy after init.
        for (int a = 0; a < DEPTH; a += 2) begin
            set_rd(a, a + 1);
            tick("clear");
        end

        // Basic write then read.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEAD_BEEF;
        set_rd(1, 2);
        tick("wr5");
        idle();
        set_rd(5, 0);
        tick("rd5");
        chk("rd5.direct", data_of(0), 32'hDEAD_BEEF);

        // Write-first bypass to both ports.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h1234_5678;
        set_rd(7, 7);
        tick("byp7");
        chk("byp7.p0", data_of(0), 32'h1234_5678);
        chk("byp7.p1", data_of(1), 32'h1234_5678);
        idle();

        // Scoreboard: issue, read busy, write clears, issue+write stays busy.
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        set_rd(3, 5);
        tick("iss3");
        idle();
        tick("busy3");
        chk("busy3.direct", {31'b0, bus.rd_busy[0]}, 32'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hA5A5_A5A5;
        tick("wr3");
        chk("wr3.data", data_of(0), 32'hA5A5_A5A5);
        chk("wr3.busy", {31'b0, bus.rd_busy[0]}, 32'd0);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3; bus.wr_data = 32'h0F0F_0F0F;
        tick("isswr3");
        chk("isswr3.busy", {31'b0, bus.rd_busy[0]}, 32'd1);
        idle();
        tick("after3");

        // Zero register ignores write, issue and bypass.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF_FFFF;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        set_rd(0, 0);
        tick("zero");
        chk("zero.data", data_of(1), 32'h0);
        idle();
        tick("zero2");
        chk("zero2.busy", {31'b0, bus.rd_busy[0]}, 32'd0);

        // Randomised traffic, addresses mostly in a narrow window to force collisions.
        for (int k = 0; k < 400; k++) begin
            bus.wr_en    = 1'($urandom_range(0, 1));
            bus.wr_addr  = ADDR_W'(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7));
            bus.wr_data  = $urandom;
            bus.iss_en   = ($urandom_range(0, 2) == 0);
            bus.iss_addr = ADDR_W'($urandom_range(0, 7));
            set_rd($urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                                      : $urandom_range(0, 7));
            tick("rand");
        end
        idle();

        // Reset mid-RUN: contents and busy bits are lost.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h55;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd12;
        tick("wr9");
        idle();
        rst_n = 1'b0;
        tick("midrst");
        chk("midrst.ready", {31'b0, bus.ready}, 32'd0);
        rst_n = 1'b1;
        set_rd(9, 12);
        for (int k = 0; k < 10; k++) tick("reinit");

        // Reset mid-INIT restarts the full clear sequence.
        rst_n = 1'b0;
        tick("initrst");
        rst_n = 1'b1;
        wait_ready("reinit2");
        tick("rd9");
        chk("rd9.data", data_of(0), 32'h0);
        chk("rd12.busy", {31'b0, bus.rd_busy[1]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
